// File: rtl/steer_pkg.sv
// steer_pkg: shared steering command encodings, scheduler state codes and frame length default
package steer_pkg;
    localparam logic [1:0] REST_STATE  = 2'b00;
    localparam logic [1:0] LEFT_STATE  = 2'b01;
    localparam logic [1:0] RIGHT_STATE = 2'b11;
    localparam int FRAME_CYCLES_DEF = 2000000;
    typedef enum logic [2:0] {S_REST, S_LEFT, S_RIGHT, S_REVERSE, S_LOST} state_t;
    function automatic logic [1:0] state_cmd(input state_t s);
        return (s == S_LEFT) ? LEFT_STATE : (s == S_RIGHT) ? RIGHT_STATE : REST_STATE;
    endfunction
endpackage

// File: rtl/steer_scheduler_frame_tick_gen.sv
// frame_tick_gen: free-running servo frame counter; clk/rst (async active-low) in, frame_tick pulse out on the last cycle of each frame
module frame_tick_gen
    import steer_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);
    logic [20:0] count;
    assign frame_tick = count == 21'(FRAME_CYCLES - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else count <= frame_tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/steer_scheduler.sv
// steer_scheduler: frame-aligned steering arbiter; in clk, rst (async active-low), enable, manual_mode, manual_req[1:0], sensor[2:0]; out follower_state[1:0], frame_tick, lost; optional STEER_SOFTSTART_EN holds REST for 50 frames after reset
module steer_scheduler
    import steer_pkg::*;
#(
    parameter int FRAME_CYCLES        = FRAME_CYCLES_DEF,
    parameter int MIN_HOLD_FRAMES     = 3,
    parameter int REVERSE_REST_FRAMES = 2,
    parameter int LOST_FRAMES         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       manual_mode,
    input  logic [1:0] manual_req,
    input  logic [2:0] sensor,
    output logic [1:0] follower_state,
    output logic       frame_tick,
    output logic       lost
);
    // One counter serves both the hold time and the reversal gap, so it saturates at the larger of the two
    localparam int CNT_MAX = (MIN_HOLD_FRAMES > REVERSE_REST_FRAMES) ? MIN_HOLD_FRAMES : REVERSE_REST_FRAMES;
    localparam int HW = $clog2(CNT_MAX + 1);
    localparam int LW = $clog2(LOST_FRAMES + 1);
    state_t state, state_n;
    logic [1:0] auto_q, auto_d, req, target_q, target_n;
    logic [HW-1:0] hold_cnt, hold_n, hold_inc;
    logic [LW-1:0] lost_cnt, lost_n, lost_inc;
    logic ss_active;
    frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick)
    );
`ifdef STEER_SOFTSTART_EN
    logic [5:0] ss_cnt;
    assign ss_active = ss_cnt != 6'd50;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ss_cnt <= '0;
        else if (frame_tick && ss_active) ss_cnt <= ss_cnt + 1'b1;
    end
`else
    assign ss_active = 1'b0;
`endif
    assign lost = state == S_LOST;
    always_comb begin
        // 101 and 000 carry no usable direction, so the previous auto request stands
        auto_d = (sensor == 3'b010 || sensor == 3'b111) ? REST_STATE :
                 (sensor == 3'b100 || sensor == 3'b110) ? LEFT_STATE :
                 (sensor == 3'b001 || sensor == 3'b011) ? RIGHT_STATE : auto_q;
        req = manual_mode ? ((manual_req == 2'b10) ? REST_STATE : manual_req) : auto_d;
        hold_inc = (hold_cnt == HW'(CNT_MAX)) ? hold_cnt : hold_cnt + 1'b1;
        lost_inc = (manual_mode || sensor != 3'b000) ? '0 :
                   (lost_cnt == LW'(LOST_FRAMES)) ? lost_cnt : lost_cnt + 1'b1;
        state_n = state;
        target_n = target_q;
        hold_n = hold_cnt;
        lost_n = manual_mode ? '0 : lost_cnt;
        if (!enable || ss_active) begin
            state_n = S_REST;
            hold_n = '0;
            lost_n = '0;
        end else if (frame_tick) begin
            hold_n = hold_inc;
            lost_n = lost_inc;
            if (lost_inc == LW'(LOST_FRAMES)) state_n = S_LOST;
            else begin
                case (state)
                    S_REST: state_n = (req == LEFT_STATE) ? S_LEFT : (req == RIGHT_STATE) ? S_RIGHT : S_REST;
                    S_LEFT, S_RIGHT: begin
                        // Hold is judged on the count including this frame
                        if (hold_inc >= HW'(MIN_HOLD_FRAMES) && req != state_cmd(state)) begin
                            state_n = (req == REST_STATE) ? S_REST : S_REVERSE;
                            target_n = req;
                        end
                    end
                    S_REVERSE: state_n = (req == REST_STATE) ? S_REST :
                                         (hold_inc >= HW'(REVERSE_REST_FRAMES)) ?
                                         ((target_q == LEFT_STATE) ? S_LEFT : S_RIGHT) : S_REVERSE;
                    S_LOST: state_n = (sensor != 3'b000) ? S_REST : S_LOST;
                    default: state_n = S_REST;
                endcase
            end
            if (state_n != state) hold_n = '0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REST;
            follower_state <= REST_STATE;
            auto_q <= REST_STATE;
            target_q <= REST_STATE;
            hold_cnt <= '0;
            lost_cnt <= '0;
        end else begin
            state <= state_n;
            follower_state <= state_cmd(state_n);
            auto_q <= auto_d;
            target_q <= target_n;
            hold_cnt <= hold_n;
            lost_cnt <= lost_n;
        end
    end
endmodule

// File: tb/tb_steer_scheduler.sv
// tb_steer_scheduler: directed and random frame-level checks of steer_scheduler against a frame-step model
module tb_steer_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    logic manual_mode = 1'b0;
    logic [1:0] manual_req = 2'b00;
    logic [2:0] sensor = 3'b010;
    logic [1:0] follower_state;
    logic frame_tick, lost;
    int total = 0;
    int bad = 0;
    int m_cmd, m_auto, m_frames, m_gap_on, m_gap_n, m_target, m_run, m_lost;
    bit skip_period = 1'b1;
    steer_scheduler #(.FRAME_CYCLES(10)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .manual_mode(manual_mode),
        .manual_req(manual_req),
        .sensor(sensor),
        .follower_state(follower_state),
        .frame_tick(frame_tick),
        .lost(lost)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    function automatic int exp_out();
        return (m_gap_on != 0 || m_lost != 0) ? 0 : m_cmd;
    endfunction
    function automatic int decode(input logic [2:0] s, input int held);
        case (s)
            3'b010, 3'b111: return 0;
            3'b100, 3'b110: return 1;
            3'b001, 3'b011: return 3;
            default: return held;
        endcase
    endfunction
    task automatic model_clear();
        m_cmd = 0; m_frames = 0; m_gap_on = 0; m_gap_n = 0; m_run = 0; m_lost = 0;
    endtask
    task automatic model_tick();
        int rq;
        m_auto = decode(sensor, m_auto);
        rq = manual_mode ? ((manual_req == 2'b10) ? 0 : int'(manual_req)) : m_auto;
        m_run = manual_mode ? 0 : (sensor == 3'b000) ? ((m_run < 25) ? m_run + 1 : 25) : 0;
        if (m_run == 25) begin
            if (m_lost == 0) begin m_lost = 1; m_gap_on = 0; m_cmd = 0; m_frames = 0; end
        end else if (m_lost != 0) begin
            if (sensor != 3'b000) begin m_lost = 0; m_cmd = 0; end
        end else if (m_gap_on != 0) begin
            m_gap_n++;
            if (rq == 0) begin m_gap_on = 0; m_cmd = 0; end
            else if (m_gap_n >= 2) begin m_gap_on = 0; m_cmd = m_target; m_frames = 0; end
        end else if (m_cmd == 0) begin
            if (rq != 0) begin m_cmd = rq; m_frames = 0; end
        end else begin
            m_frames++;
            if (m_frames >= 3 && rq != m_cmd) begin
                if (rq == 0) m_cmd = 0;
                else begin m_gap_on = 1; m_gap_n = 0; m_target = rq; end
            end
        end
    endtask
    task automatic run_frame(input logic [2:0] s, input logic mm, input logic [1:0] mr, input string tag);
        int n = 0;
        sensor = s; manual_mode = mm; manual_req = mr;
        while (!frame_tick && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_tick", tag), frame_tick, 1);
        if (!skip_period) chk($sformatf("%s_period", tag), n, 9);
        skip_period = 1'b0;
        chk($sformatf("%s_pre", tag), follower_state, exp_out());
        model_tick();
        @(negedge clk);
        chk($sformatf("%s_cmd", tag), follower_state, exp_out());
        chk($sformatf("%s_lost", tag), lost, m_lost);
        chk($sformatf("%s_tick_low", tag), frame_tick, 0);
    endtask
    task automatic en_pulse(input string tag);
        enable = 1'b0;
        @(negedge clk);
        model_clear();
        chk($sformatf("%s_en_cmd", tag), follower_state, exp_out());
        chk($sformatf("%s_en_lost", tag), lost, 0);
        enable = 1'b1;
        skip_period = 1'b1;
    endtask
    initial begin
        logic [2:0] stab [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        repeat (3) @(negedge clk);
        chk("rst_cmd", follower_state, 0);
        chk("rst_lost", lost, 0);
        chk("rst_tick", frame_tick, 0);
        model_clear();
        m_auto = 0;
        rst = 1'b1;
        repeat (2) run_frame(3'b010, 1'b0, 2'b00, "idle");
        run_frame(3'b100, 1'b0, 2'b00, "to_left");
        repeat (5) run_frame(3'b001, 1'b0, 2'b00, "left_to_right");
        chk("right_reached", follower_state, 3);
        repeat (3) run_frame(3'b001, 1'b0, 2'b00, "right_hold");
        run_frame(3'b110, 1'b0, 2'b00, "right_rev");
        run_frame(3'b010, 1'b0, 2'b00, "gap_rest");
        repeat (3) run_frame(3'b101, 1'b0, 2'b00, "gap_after");
        run_frame(3'b100, 1'b0, 2'b00, "left2");
        repeat (3) run_frame(3'b100, 1'b0, 2'b00, "left2_hold");
        run_frame(3'b010, 1'b0, 2'b00, "left2_rest");
        repeat (26) run_frame(3'b000, 1'b0, 2'b00, "dark25");
        chk("lost_set", lost, 1);
        run_frame(3'b010, 1'b0, 2'b00, "lost_exit");
        repeat (24) run_frame(3'b000, 1'b0, 2'b00, "dark24");
        run_frame(3'b011, 1'b0, 2'b00, "dark24_end");
        run_frame(3'b010, 1'b0, 2'b00, "man_pre");
        run_frame(3'b010, 1'b1, 2'b10, "man_10");
        run_frame(3'b010, 1'b1, 2'b11, "man_11");
        repeat (30) run_frame(3'b000, 1'b1, 2'b11, "man_dark");
        run_frame(3'b001, 1'b0, 2'b00, "auto_right");
        chk("pre_enable", follower_state, exp_out());
        en_pulse("en_mid_right");
        repeat (2) run_frame(3'b010, 1'b0, 2'b00, "after_en");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) en_pulse("rnd");
            else run_frame(stab[$urandom_range(0, 7)], $urandom_range(0, 5) == 0,
                           2'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end
        en_pulse("pre_rst");
        run_frame(3'b100, 1'b0, 2'b00, "rst_left");
        chk("rst_left_state", follower_state, exp_out());
        #1 rst = 1'b0;
        #1;
        chk("arst_cmd", follower_state, 0);
        chk("arst_lost", lost, 0);
        chk("arst_tick", frame_tick, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/steer_scheduler.md
Name: steer_scheduler

Overview:
- Decides the steering command `follower_state` that drives the servo PWM handler.
- Arbitrates between two requesters: the line sensors (auto) and the board switches (manual).
- Commits changes only on 20 ms servo-frame boundaries. Enforces a minimum hold time, inserts a REST gap on every direction reversal, and falls back to REST when the line is lost.

Parameters:
- FRAME_CYCLES, 2000000: clk cycles per servo frame (20 ms at 100 MHz).
- MIN_HOLD_FRAMES, 3: frames a LEFT/RIGHT command is held before it may change.
- REVERSE_REST_FRAMES, 2: REST frames inserted between LEFT and RIGHT.
- LOST_FRAMES, 25: consecutive all-dark frames before the lost-line fallback.

Ports:
- clk  in  1  100 MHz board clock.
- rst  in  1  reset; asynchronous, active-low.
- enable  in  1  0 forces REST.
- manual_mode  in  1  1 selects the manual requester.
- manual_req  in  2  manual command; 00 REST, 01 LEFT, 11 RIGHT, 10 treated as REST.
- sensor  in  3  {left, centre, right}; 1 = line seen. Already synchronised upstream.
- follower_state  out  2  command to the servo handler; 00 REST, 01 LEFT, 11 RIGHT.
- frame_tick  out  1  one-cycle pulse at each frame end.
- lost  out  1  high while in S_LOST.

Behaviour:
- Reset (rst=0, async): follower_state=00, frame_tick=0, lost=0, FSM=S_REST, all counters 0.
- Frame counter:
  - 21-bit, counts 0..FRAME_CYCLES-1 and wraps to 0.
  - frame_tick=1 exactly while the count equals FRAME_CYCLES-1.
- Auto request decode from sensor:
  - 010 or 111 -> REST.
  - 100 or 110 -> LEFT.
  - 001 or 011 -> RIGHT.
  - 101 -> hold current request.
  - 000 -> dark; hold current request.
- Arbiter: manual_mode=1 selects manual_req; dark detection and lost counting are disabled and lost_cnt is held at 0.
- FSM states: S_REST, S_LEFT, S_RIGHT, S_REVERSE, S_LOST. Transitions are evaluated only in a frame_tick cycle and take effect at the next clk edge.
- hold_cnt: cleared on state entry; increments each frame_tick; saturates at MIN_HOLD_FRAMES.
- S_REST: request LEFT -> S_LEFT; request RIGHT -> S_RIGHT. No hold requirement.
- S_LEFT / S_RIGHT:
  - Changes are allowed only when hold_cnt == MIN_HOLD_FRAMES.
  - Request REST -> S_REST.
  - Request of the opposite direction -> S_REVERSE; the target direction is latched.
- S_REVERSE:
  - Outputs REST.
  - After REVERSE_REST_FRAMES frame_ticks -> the latched target.
  - A REST request during the gap -> S_REST.
  - Other request changes during the gap are ignored.
- Lost-line fallback:
  - lost_cnt increments on each frame_tick with sensor=000 (auto mode only), saturating at LOST_FRAMES.
  - Any non-000 frame_tick clears lost_cnt.
  - lost_cnt reaching LOST_FRAMES -> S_LOST from any state; this overrides the hold rule.
  - S_LOST: outputs REST, lost=1. First frame_tick with sensor!=000 -> S_REST.
- enable=0:
  - Next clk edge: FSM=S_REST; hold_cnt, lost_cnt and the reverse counter cleared; follower_state=00.
  - The frame counter keeps running.
- follower_state is a registered decode of the FSM state, so it changes exactly one cycle after frame_tick. Encoding 10 is never output.
- Simultaneous events, priority highest first: enable=0, lost timeout, normal FSM transition.

Optional Feature:
- Macro: STEER_SOFTSTART_EN.
- Defined: after reset release, follower_state is forced to 00 for 50 frames (1 s). Requests are ignored during this window and counting resumes afterwards.
- Undefined: normal operation from the first frame after reset.

Decomposition:
- Shared package `steer_pkg`:
  - Command encodings REST_STATE=2'b00, LEFT_STATE=2'b01, RIGHT_STATE=2'b11, also used by the servo handler.
  - FSM state codes.
  - FRAME_CYCLES default.
- One sub-module, `frame_tick_gen`: frame counter plus frame_tick. Reusable by the servo handler to align PWM frames.

Test Plan (bench uses FRAME_CYCLES=10):
- Reset then idle, sensor=010 -> follower_state=00, frame_tick period 10 cycles, lost=0.
- sensor=100 before tick 1 -> follower_state=01 one cycle after tick 1. sensor=001 at tick 2 -> still 01 until hold met at tick 4; then 00 for 2 frames; 11 after tick 6.
- In S_LEFT with hold met, sensor=010 -> 00 one cycle after the next tick. In S_REVERSE, sensor=010 at the first gap tick -> stays 00 and never reaches 11.
- sensor=000 for 25 ticks with LOST_FRAMES=25 -> lost=1, follower_state=00. sensor=010 -> S_REST at the next tick, lost=0. 24 dark ticks then 010 -> no lost.
- manual_mode=1, manual_req=10 -> 00. manual_req=11 -> 11 at the next tick. sensor=000 for 30 ticks -> lost stays 0.
- enable=0 mid-S_RIGHT -> 00 next cycle, no wait for tick. Assert rst=0 mid-frame -> all outputs 0 immediately, asynchronously.
